ac_i2c_responder: RTL and testbench
===================================

// Module: ac_i2c_responder
// PURPOSE
//  I2C responder (slave) model of the SSM2603 audio-codec control port. It is the other
//  end of the codec driver's I2C initiator: it decodes 16-bit write words
//  (7-bit reg addr + 9-bit data), ACKs them and keeps a shadow register file.
//  Used in simulation and on-FPGA loopback to check codec configuration sequences
//  without the physical codec.
// PARAMETERS
//  DEV_ADDR    7'h1A  7-bit I2C device address this block answers to
//  FILTER_LEN  3      clk cycles SCL/SDA must be stable before a level change is accepted
//  N_REGS      16     shadow register file depth (reg addr 0..N_REGS-1)
// PORTS
//  clk        in   1  system clock, all logic on rising edge; SCL freq <= clk/(8*FILTER_LEN)
//  reset_n    in   1  asynchronous active-low reset
//  sclkIn     in   1  I2C SCL, asynchronous input
//  sdatIn     in   1  I2C SDA read-back, asynchronous input
//  sdatOe     out  1  1 = pull SDA low (open-drain); 0 = release
//  wrEn       out  1  one-clk pulse: a complete word was accepted
//  wrAddr     out  7  register address of accepted word, valid with wrEn, held after
//  wrData     out  9  register data of accepted word, valid with wrEn, held after
//  rdAddr     in   7  shadow file read address
//  rdData     out  9  shadow file content at rdAddr, combinational; 0 if rdAddr >= N_REGS
//  busy       out  1  1 between accepted START and STOP
//  protoErr   out  1  one-clk pulse: STOP/repeated START inside an unfinished word
// BEHAVIOUR
//  Reset: sdatOe=0, wrEn=0, wrAddr=0, wrData=0, busy=0, protoErr=0, state IDLE,
//   shadow file = REG_RESET_VAL table (package); filters preset to 1 (bus idle high).
//  Input path: 2-flop sync per line -> stability filter (FILTER_LEN equal samples)
//   -> edge detect. Glitches shorter than FILTER_LEN clk never reach the FSM.
//  START = filtered SDA fall while SCL high; STOP = SDA rise while SCL high.
//   Both are detected in every state; START has priority over data on the same clk.
//  Data sampled on filtered SCL rise, MSB first; sdatOe changes only on filtered SCL fall.
//  FSM: IDLE -START-> ADDR (8 bits: 7 addr + R/W)
//   ADDR: addr==DEV_ADDR && R/W==0 -> ACK_A, else -> WAIT_STOP (no ACK; reads unsupported)
//   ACK_A -> BYTE_HI (bits: regAddr[6:0], data[8]) -> ACK_H -> BYTE_LO (data[7:0])
//   -> ACK_L -> WAIT_STOP (extra bytes get no ACK, are discarded)
//   WAIT_STOP: only STOP -> IDLE or START -> ADDR.
//  ACK slot: sdatOe=1 from the SCL fall ending bit 8 to the SCL fall ending the 9th clock.
//  wrEn: pulsed on the clk after the SCL fall that starts ACK_L; wrAddr/wrData update same clk.
//   Shadow file written same clk if addr < N_REGS; addr 7'h0F (reset reg) reloads
//   REG_RESET_VAL for all entries instead. wrEn still pulses for addr >= N_REGS.
//  STOP or START in ADDR (after >=1 bit), BYTE_HI, BYTE_LO or any ACK slot before wrEn:
//   word dropped, no wrEn, protoErr pulse, sdatOe released within 1 clk.
//  busy=1 from START detect clk to STOP detect clk (repeated START keeps busy=1).
//  reset_n low mid-transfer: immediate return to reset values incl. shadow file; next
//   activity needs a fresh START.
// STRUCTURE
//  Package ac_i2c_pkg: state enum, REG_RESET_VAL[16] (SSM2603 defaults, e.g. reg0=9'h097,
//   reg4=9'h00A, reg6=9'h09F), RESET_REG_ADDR=7'h0F.
//  Sub-module ac_i2c_line_filter (sync + stability filter + rise/fall), instanced for SCL, SDA.
// TESTING
//  1 Write dev 0x1A, reg 0x04, data 0x012 -> ACK on 3 slots, single wrEn, wrAddr=4,
//    wrData=0x012, rdData(rdAddr=4)=0x012, busy falls at STOP.
//  2 Dev addr 0x1B, then 0x1A with R/W=1 -> sdatOe never asserted, no wrEn, no protoErr.
//  3 Valid addr + first data byte, then STOP -> protoErr pulse, no wrEn, shadow unchanged.
//  4 Write reg 0x06=0x000, then reg 0x0F=0x000 -> rdData(6) returns 9'h09F.
//  5 SCL pulses of FILTER_LEN-1 clk injected while idle and during a byte -> ignored,
//    transfer completes normally.
//  6 reset_n pulsed during BYTE_LO -> all outputs at reset values; next full write accepted.

Source files
------------

// File: rtl/ac_i2c_pkg.sv
// Shared types and constants for the SSM2603 control-port responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ac_i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_A,
        ST_BYTE_HI,
        ST_ACK_H,
        ST_BYTE_LO,
        ST_ACK_L,
        ST_WAIT_STOP
    } i2c_state_t;

    // Writing any data to this register restores every shadow entry to its default.
    localparam logic [6:0] RESET_REG_ADDR = 7'h0F;

    // SSM2603 power-on register contents, regs 0..15.
    localparam logic [8:0] REG_RESET_VAL [16] = '{
        9'h097, 9'h097, 9'h079, 9'h079,
        9'h00A, 9'h008, 9'h09F, 9'h00A,
        9'h000, 9'h000, 9'h000, 9'h000,
        9'h000, 9'h000, 9'h000, 9'h000
    };

    // Default for any register address; addresses beyond the table read as zero.
    function automatic logic [8:0] reg_reset_val(input logic [6:0] idx);
        return (idx < 7'd16) ? REG_RESET_VAL[idx[3:0]] : 9'h000;
    endfunction

endpackage

// File: rtl/ac_i2c_line_filter.sv
// Synchroniser + stability filter + edge detector for one open-drain I2C line.
// Latency: 2 sync flops + FILTER_LEN equal samples before filt/rise/fall move.
// Backpressure: none; free-running on every clk.
// Ports: clk, reset_n (async active-low), line_in (async), filt (debounced level),
//        rise/fall (one-clk pulses, asserted on the same clk filt changes).
module ac_i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic line_in,
    output logic filt,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // cnt counts consecutive synced samples that disagree with filt; any agreeing
    // sample restarts it, so pulses shorter than FILTER_LEN clk are swallowed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= 2'b11;
            filt <= 1'b1;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[0], line_in};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync[1] == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                filt <= sync[1];
                cnt  <= '0;
                rise <= sync[1];
                fall <= ~sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ac_i2c_responder.sv
// I2C write-only responder modelling the SSM2603 control port with a shadow register file.
// Latency: ACK/wrEn follow the filtered SCL fall (2 sync + FILTER_LEN clk after the pin edge).
// Backpressure: none; the bus initiator paces everything, SCL must stay <= clk/(8*FILTER_LEN).
// Ports: clk, reset_n, sclkIn/sdatIn (bus inputs), sdatOe (pull SDA low), wrEn/wrAddr/wrData
//        (accepted word), rdAddr/rdData (combinational shadow read), busy, protoErr.
module ac_i2c_responder
    import ac_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = 7'h1A,
    parameter int         FILTER_LEN = 3,
    parameter int         N_REGS     = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sclkIn,
    input  logic       sdatIn,
    output logic       sdatOe,
    output logic       wrEn,
    output logic [6:0] wrAddr,
    output logic [8:0] wrData,
    input  logic [6:0] rdAddr,
    output logic [8:0] rdData,
    output logic       busy,
    output logic       protoErr
);

    localparam int AW = $clog2(N_REGS);

    logic       scl_filt, scl_rise, scl_fall;
    logic       sda_filt, sda_rise, sda_fall;
    logic       start_det, stop_det, word_open, in_byte, bit_in, byte_done;
    i2c_state_t state;
    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] hi_byte;
    logic [8:0] shadow [N_REGS];
    logic [AW-1:0] wr_idx;

    ac_i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk(clk), .reset_n(reset_n), .line_in(sclkIn),
        .filt(scl_filt), .rise(scl_rise), .fall(scl_fall)
    );

    ac_i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk(clk), .reset_n(reset_n), .line_in(sdatIn),
        .filt(sda_filt), .rise(sda_rise), .fall(sda_fall)
    );

    assign start_det = sda_fall && scl_filt;
    assign stop_det  = sda_rise && scl_filt;
    assign in_byte   = (state == ST_ADDR) || (state == ST_BYTE_HI) || (state == ST_BYTE_LO);
    assign bit_in    = scl_rise && (bit_cnt != 4'd8);
    assign byte_done = scl_fall && (bit_cnt == 4'd8);
    assign wr_idx    = hi_byte[AW:1];

    // A word is "open" once the address phase has clocked a bit and until wrEn fires;
    // an address phase with zero bits is just START immediately followed by START/STOP.
    assign word_open = ((state == ST_ADDR) && (bit_cnt != 4'd0)) ||
                       (state == ST_ACK_A) || (state == ST_BYTE_HI) ||
                       (state == ST_ACK_H) || (state == ST_BYTE_LO);

    assign rdData = (int'(rdAddr) < N_REGS) ? shadow[rdAddr[AW-1:0]] : 9'h000;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= 4'd0;
            shift    <= 8'h00;
            hi_byte  <= 8'h00;
            sdatOe   <= 1'b0;
            wrEn     <= 1'b0;
            wrAddr   <= 7'h00;
            wrData   <= 9'h000;
            busy     <= 1'b0;
            protoErr <= 1'b0;
            for (int i = 0; i < N_REGS; i++) shadow[i] <= reg_reset_val(7'(i));
        end else begin
            wrEn     <= 1'b0;
            protoErr <= 1'b0;
            // Bus conditions override whatever the data path was doing this clk.
            if (start_det || stop_det) begin
                protoErr <= word_open;
                sdatOe   <= 1'b0;
                bit_cnt  <= 4'd0;
                busy     <= start_det;
                state    <= start_det ? ST_ADDR : ST_IDLE;
            end else begin
                if (in_byte && bit_in) begin
                    shift   <= {shift[6:0], sda_filt};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                case (state)
                    ST_ADDR: begin
                        if (byte_done) begin
                            bit_cnt <= 4'd0;
                            if (shift == {DEV_ADDR, 1'b0}) begin
                                state  <= ST_ACK_A;
                                sdatOe <= 1'b1;
                            end else begin
                                state  <= ST_WAIT_STOP;
                            end
                        end
                    end
                    ST_BYTE_HI: begin
                        if (byte_done) begin
                            bit_cnt <= 4'd0;
                            hi_byte <= shift;
                            state   <= ST_ACK_H;
                            sdatOe  <= 1'b1;
                        end
                    end
                    ST_BYTE_LO: begin
                        if (byte_done) begin
                            bit_cnt <= 4'd0;
                            state   <= ST_ACK_L;
                            sdatOe  <= 1'b1;
                            wrEn    <= 1'b1;
                            wrAddr  <= hi_byte[7:1];
                            wrData  <= {hi_byte[0], shift};
                            if (hi_byte[7:1] == RESET_REG_ADDR) begin
                                for (int i = 0; i < N_REGS; i++) shadow[i] <= reg_reset_val(7'(i));
                            end else if (int'(hi_byte[7:1]) < N_REGS) begin
                                shadow[wr_idx] <= {hi_byte[0], shift};
                            end
                        end
                    end
                    ST_ACK_A: if (scl_fall) begin sdatOe <= 1'b0; state <= ST_BYTE_HI;   end
                    ST_ACK_H: if (scl_fall) begin sdatOe <= 1'b0; state <= ST_BYTE_LO;   end
                    ST_ACK_L: if (scl_fall) begin sdatOe <= 1'b0; state <= ST_WAIT_STOP; end
                    ST_IDLE, ST_WAIT_STOP: ;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ac_i2c_responder.sv
// Directed bench for ac_i2c_responder: bit-banged I2C initiator on a wired-AND SDA.
// Latency: n/a.
// Backpressure: n/a.
module tb_ac_i2c_responder;

    localparam int FL = 3;
    localparam int Q  = 8;   // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       reset_n;
    logic       scl_m, sda_m, sda_bus;
    logic       sdat_oe, wr_en, busy, proto_err;
    logic [6:0] wr_addr, rd_addr;
    logic [8:0] wr_data, rd_data;

    int n_cmp = 0, n_fail = 0;
    int wr_cnt = 0, perr_cnt = 0, oe_cnt = 0;
    logic oe_prev = 1'b0;

    assign sda_bus = sda_m & ~sdat_oe;

    always #5 clk = ~clk;

    ac_i2c_responder #(.DEV_ADDR(7'h1A), .FILTER_LEN(FL), .N_REGS(16)) dut (
        .clk(clk), .reset_n(reset_n), .sclkIn(scl_m), .sdatIn(sda_bus),
        .sdatOe(sdat_oe), .wrEn(wr_en), .wrAddr(wr_addr), .wrData(wr_data),
        .rdAddr(rd_addr), .rdData(rd_data), .busy(busy), .protoErr(proto_err)
    );

    always @(negedge clk) begin
        if (wr_en) wr_cnt++;
        if (proto_err) perr_cnt++;
        if (sdat_oe && !oe_prev) oe_cnt++;
        oe_prev = sdat_oe;
    end

    typedef struct {
        logic [6:0] dev;
        logic       rw;
        logic [6:0] ra;
        logic [8:0] dat;
        logic [2:0] exp_ack;
        int         exp_wr;
        int         exp_oe;
        logic [6:0] chk_ra;
        logic [8:0] chk_val;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_rd(input string name, input logic [6:0] a, input logic [8:0] exp);
        rd_addr = a;
        #1;
        chk(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic i2c_start();
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); sda_m = 1'b0;
        wait_clk(Q); scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_stop();
        wait_clk(Q); sda_m = 1'b0;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(2 * Q);
    endtask

    task automatic send_bit(input logic b, input logic glitch, output logic s);
        wait_clk(Q); sda_m = b;
        if (glitch) begin
            wait_clk(2); scl_m = 1'b1;
            wait_clk(FL - 1); scl_m = 1'b0;
            wait_clk(Q - 2 - (FL - 1));
        end else begin
            wait_clk(Q);
        end
        scl_m = 1'b1;
        wait_clk(Q); s = sda_bus;
        wait_clk(Q); scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gbit, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], gbit == i, s);
        send_bit(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic write_txn(input logic [6:0] dev, input logic rw, input logic [6:0] ra,
                             input logic [8:0] dat, input int gbyte, input int gbit,
                             output logic [2:0] acks);
        logic a0, a1, a2;
        i2c_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        send_byte({dev, rw}, (gbyte == 0) ? gbit : -1, a0);
        send_byte({ra, dat[8]}, (gbyte == 1) ? gbit : -1, a1);
        send_byte(dat[7:0], (gbyte == 2) ? gbit : -1, a2);
        i2c_stop();
        acks = {a0, a1, a2};
    endtask

    initial begin
        logic [2:0] acks;
        logic       a, s;
        logic [6:0] last_a;
        logic [8:0] last_d;
        int w0, p0, o0;

        vecs[0] = '{7'h1A, 1'b0, 7'h04, 9'h012, 3'b111, 1, 3, 7'h04, 9'h012};
        vecs[1] = '{7'h1B, 1'b0, 7'h05, 9'h1FF, 3'b000, 0, 0, 7'h05, 9'h008};
        vecs[2] = '{7'h1A, 1'b1, 7'h05, 9'h1FF, 3'b000, 0, 0, 7'h05, 9'h008};
        vecs[3] = '{7'h1A, 1'b0, 7'h06, 9'h000, 3'b111, 1, 3, 7'h06, 9'h000};
        vecs[4] = '{7'h1A, 1'b0, 7'h0F, 9'h000, 3'b111, 1, 3, 7'h06, 9'h09F};
        vecs[5] = '{7'h1A, 1'b0, 7'h14, 9'h155, 3'b111, 1, 3, 7'h14, 9'h000};
        vecs[6] = '{7'h1A, 1'b0, 7'h00, 9'h1AB, 3'b111, 1, 3, 7'h00, 9'h1AB};

        reset_n = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rd_addr = 7'h00;
        #2 reset_n = 1'b0;
        wait_clk(3);
        chk("rst_sdatOe",   32'(sdat_oe),   32'd0);
        chk("rst_wrEn",     32'(wr_en),     32'd0);
        chk("rst_wrAddr",   32'(wr_addr),   32'd0);
        chk("rst_wrData",   32'(wr_data),   32'd0);
        chk("rst_busy",     32'(busy),      32'd0);
        chk("rst_protoErr", 32'(proto_err), 32'd0);
        check_rd("rst_rd0",  7'd0,  9'h097);
        check_rd("rst_rd6",  7'd6,  9'h09F);
        check_rd("rst_rd20", 7'd20, 9'h000);
        wait_clk(2);
        reset_n = 1'b1;
        wait_clk(Q);
        last_a = 7'h00; last_d = 9'h000;

        // START then STOP with no clock at all: not an unfinished word.
        p0 = perr_cnt;
        sda_m = 1'b0; wait_clk(2 * Q);
        chk("ss_busy_hi", 32'(busy), 32'd1);
        sda_m = 1'b1; wait_clk(2 * Q);
        chk("ss_busy_lo", 32'(busy), 32'd0);
        chk("ss_perr", 32'(perr_cnt - p0), 32'd0);

        for (int v = 0; v < 7; v++) begin
            w0 = wr_cnt; p0 = perr_cnt; o0 = oe_cnt;
            write_txn(vecs[v].dev, vecs[v].rw, vecs[v].ra, vecs[v].dat, -1, -1, acks);
            if (vecs[v].exp_wr != 0) begin last_a = vecs[v].ra; last_d = vecs[v].dat; end
            chk($sformatf("v%0d_acks", v),   32'(acks), 32'(vecs[v].exp_ack));
            chk($sformatf("v%0d_wrcnt", v),  32'(wr_cnt - w0), 32'(vecs[v].exp_wr));
            chk($sformatf("v%0d_oecnt", v),  32'(oe_cnt - o0), 32'(vecs[v].exp_oe));
            chk($sformatf("v%0d_perr", v),   32'(perr_cnt - p0), 32'd0);
            chk($sformatf("v%0d_wrAddr", v), 32'(wr_addr), 32'(last_a));
            chk($sformatf("v%0d_wrData", v), 32'(wr_data), 32'(last_d));
            chk($sformatf("v%0d_busy", v),   32'(busy), 32'd0);
            check_rd($sformatf("v%0d_rd", v), vecs[v].chk_ra, vecs[v].chk_val);
        end

        // Wrong device, repeated START, then right device with R/W=1: silent.
        w0 = wr_cnt; p0 = perr_cnt; o0 = oe_cnt;
        i2c_start();
        send_byte({7'h1B, 1'b0}, -1, a);
        chk("rs_ack1", 32'(a), 32'd0);
        i2c_start();
        chk("rs_busy", 32'(busy), 32'd1);
        send_byte({7'h1A, 1'b1}, -1, a);
        chk("rs_ack2", 32'(a), 32'd0);
        i2c_stop();
        chk("rs_oe",   32'(oe_cnt - o0),   32'd0);
        chk("rs_wr",   32'(wr_cnt - w0),   32'd0);
        chk("rs_perr", 32'(perr_cnt - p0), 32'd0);
        chk("rs_busy_end", 32'(busy), 32'd0);

        // STOP after the first data byte drops the word.
        w0 = wr_cnt; p0 = perr_cnt;
        i2c_start();
        send_byte({7'h1A, 1'b0}, -1, a);
        send_byte({7'h02, 1'b1}, -1, a);
        chk("ab_ack_hi", 32'(a), 32'd1);
        i2c_stop();
        chk("ab_perr", 32'(perr_cnt - p0), 32'd1);
        chk("ab_wr",   32'(wr_cnt - w0),   32'd0);
        chk("ab_oe",   32'(sdat_oe), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        check_rd("ab_rd2", 7'h02, 9'h079);

        // Repeated START three bits into the address, then a clean write.
        w0 = wr_cnt; p0 = perr_cnt;
        i2c_start();
        send_bit(1'b0, 1'b0, s); send_bit(1'b0, 1'b0, s); send_bit(1'b1, 1'b0, s);
        i2c_start();
        chk("ra_busy", 32'(busy), 32'd1);
        chk("ra_perr", 32'(perr_cnt - p0), 32'd1);
        send_byte({7'h1A, 1'b0}, -1, a);
        send_byte({7'h09, 1'b0}, -1, a);
        send_byte(8'h01, -1, a);
        chk("ra_ack_lo", 32'(a), 32'd1);
        i2c_stop();
        chk("ra_wr", 32'(wr_cnt - w0), 32'd1);
        chk("ra_perr_end", 32'(perr_cnt - p0), 32'd1);
        check_rd("ra_rd9", 7'h09, 9'h001);

        // Short SCL pulses while idle and inside a data byte.
        w0 = wr_cnt; p0 = perr_cnt;
        scl_m = 1'b0; wait_clk(FL - 1); scl_m = 1'b1;
        wait_clk(Q);
        chk("gl_idle_busy", 32'(busy), 32'd0);
        write_txn(7'h1A, 1'b0, 7'h08, 9'h1C5, 1, 4, acks);
        chk("gl_acks",   32'(acks), 32'd7);
        chk("gl_wr",     32'(wr_cnt - w0), 32'd1);
        chk("gl_perr",   32'(perr_cnt - p0), 32'd0);
        chk("gl_wrAddr", 32'(wr_addr), 32'h08);
        chk("gl_wrData", 32'(wr_data), 32'h1C5);
        check_rd("gl_rd8", 7'h08, 9'h1C5);

        // Reset pulled in the middle of the low data byte.
        w0 = wr_cnt;
        i2c_start();
        send_byte({7'h1A, 1'b0}, -1, a);
        send_byte({7'h03, 1'b0}, -1, a);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, s);
        reset_n = 1'b0;
        wait_clk(2);
        chk("mr_sdatOe", 32'(sdat_oe), 32'd0);
        chk("mr_wrEn",   32'(wr_en),   32'd0);
        chk("mr_wrAddr", 32'(wr_addr), 32'd0);
        chk("mr_wrData", 32'(wr_data), 32'd0);
        chk("mr_busy",   32'(busy),    32'd0);
        chk("mr_perr",   32'(proto_err), 32'd0);
        chk("mr_wr",     32'(wr_cnt - w0), 32'd0);
        check_rd("mr_rd0", 7'h00, 9'h097);
        sda_m = 1'b1; scl_m = 1'b1;
        wait_clk(2);
        reset_n = 1'b1;
        wait_clk(Q);
        w0 = wr_cnt;
        write_txn(7'h1A, 1'b0, 7'h07, 9'h0C3, -1, -1, acks);
        chk("pr_acks",   32'(acks), 32'd7);
        chk("pr_wr",     32'(wr_cnt - w0), 32'd1);
        chk("pr_wrAddr", 32'(wr_addr), 32'h07);
        chk("pr_wrData", 32'(wr_data), 32'h0C3);
        check_rd("pr_rd7", 7'h07, 9'h0C3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
